// File: rtl/booth_pkg.sv
// Shared widths, FSM state encoding and accumulator/output arithmetic helpers for
// the Booth multiplier back-end stages.
package booth_pkg;

  localparam int PROD_W = 32;
  localparam int ACC_W  = 40;
  localparam int OUT_W  = 32;
  localparam int CNT_W  = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_e;

  typedef struct packed {
    logic [ACC_W-1:0] sum;
    logic             ovf;
  } sat_add_t;

  // OUT_W signed limits, sign-extended to ACC_W for range comparison
  localparam logic [ACC_W-1:0] OUT_MAX_EXT = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] OUT_MIN_EXT = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  function automatic logic [ACC_W-1:0] sext(input logic [PROD_W-1:0] p);
    return {{(ACC_W-PROD_W){p[PROD_W-1]}}, p};
  endfunction

  function automatic sat_add_t sat_add(input logic [ACC_W-1:0] a, input logic [ACC_W-1:0] b);
    sat_add_t         r;
    logic [ACC_W-1:0] s;
    s = a + b;
    if ((a[ACC_W-1] == b[ACC_W-1]) && (s[ACC_W-1] != a[ACC_W-1])) begin
      r.ovf = 1'b1;
      r.sum = a[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end else begin
      r.ovf = 1'b0;
      r.sum = s;
    end
    return r;
  endfunction

  function automatic logic fits_out(input logic [ACC_W-1:0] a);
    return ($signed(a) <= $signed(OUT_MAX_EXT)) && ($signed(a) >= $signed(OUT_MIN_EXT));
  endfunction

  function automatic logic [OUT_W-1:0] clamp(input logic [ACC_W-1:0] a);
    logic [OUT_W-1:0] r;
    if (fits_out(a)) begin
      r = a[OUT_W-1:0];
    end else if (a[ACC_W-1]) begin
      r = {1'b1, {(OUT_W-1){1'b0}}};
    end else begin
      r = {1'b0, {(OUT_W-1){1'b1}}};
    end
    return r;
  endfunction

endpackage

// File: rtl/booth_dot_accumulator_if.sv
// Product-in / frame-result-out stream bundle for booth_dot_accumulator.
interface booth_dot_accumulator_if;
  import booth_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [PROD_W-1:0] in_product;
  logic              in_last;
  logic              cfg_saturate;
  logic              out_valid;
  logic              out_ready;
  logic [OUT_W-1:0]  out_sum;
  logic              out_overflow;
  logic [CNT_W-1:0]  out_count;
  logic              busy;

  modport master (
    output in_valid, in_product, in_last, cfg_saturate, out_ready,
    input  in_ready, out_valid, out_sum, out_overflow, out_count, busy
  );

  modport slave (
    input  in_valid, in_product, in_last, cfg_saturate, out_ready,
    output in_ready, out_valid, out_sum, out_overflow, out_count, busy
  );

endinterface

// File: rtl/sat_clamp.sv
// Maps a wide signed accumulator to OUT_W bits by clamping or truncation and
// flags values outside the OUT_W signed range.
import booth_pkg::*;

module sat_clamp (
  input  logic [ACC_W-1:0] acc_i,
  input  logic             saturate_i,
  output logic [OUT_W-1:0] sum_o,
  output logic             oor_o
);

  // select clamped or truncated view; range flag is independent of the mode
  always_comb begin
    sum_o = acc_i[OUT_W-1:0];
    oor_o = ~fits_out(acc_i);
    if (saturate_i) begin
      sum_o = clamp(acc_i);
    end else begin
      sum_o = acc_i[OUT_W-1:0];
    end
  end

endmodule

// File: rtl/booth_dot_accumulator.sv
// Accumulates a frame of signed Booth products into a guarded-width sum and
// presents the frame total, beat count and overflow on a valid/ready port.
import booth_pkg::*;

module booth_dot_accumulator (
  input  logic                    clk,
  input  logic                    rst,
  booth_dot_accumulator_if.slave  bus
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_e           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             acc_ovf_q, acc_ovf_d;

  logic             in_ready_q;
  logic             busy_q;
  logic             out_valid_q;
  logic [OUT_W-1:0] out_sum_q;
  logic             out_overflow_q;
  logic [CNT_W-1:0] out_count_q;

  logic             beat_fire;
  logic             res_fire;
  logic             load_res;
  sat_add_t         add_res;
  logic [OUT_W-1:0] clamp_sum;
  logic             clamp_oor;

  assign beat_fire = bus.in_valid & in_ready_q;
  assign res_fire  = out_valid_q & bus.out_ready;
  assign add_res   = sat_add(acc_q, sext(bus.in_product));
  assign load_res  = (state_d == DONE) && (state_q != DONE);

  // next-state, accumulator and beat counter
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    acc_ovf_d = acc_ovf_q;
    case (state_q)
      IDLE: begin
        if (beat_fire) begin
          acc_d     = sext(bus.in_product);
          cnt_d     = CNT_ONE;
          acc_ovf_d = 1'b0;
          state_d   = bus.in_last ? DONE : ACCUM;
        end else begin
          state_d = IDLE;
        end
      end
      ACCUM: begin
        if (beat_fire) begin
          acc_d     = add_res.sum;
          acc_ovf_d = acc_ovf_q | add_res.ovf;
          cnt_d     = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
          state_d   = bus.in_last ? DONE : ACCUM;
        end else begin
          state_d = ACCUM;
        end
      end
      DONE: begin
        if (res_fire) begin
          state_d   = IDLE;
          acc_d     = {ACC_W{1'b0}};
          cnt_d     = {CNT_W{1'b0}};
          acc_ovf_d = 1'b0;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d   = IDLE;
        acc_d     = {ACC_W{1'b0}};
        cnt_d     = {CNT_W{1'b0}};
        acc_ovf_d = 1'b0;
      end
    endcase
  end

  // the result is mapped from the value the accumulator takes on the DONE entry edge
  sat_clamp u_sat_clamp (
    .acc_i      (acc_d),
    .saturate_i (bus.cfg_saturate),
    .sum_o      (clamp_sum),
    .oor_o      (clamp_oor)
  );

  // FSM and datapath state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      acc_q     <= {ACC_W{1'b0}};
      cnt_q     <= {CNT_W{1'b0}};
      acc_ovf_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      acc_ovf_q <= acc_ovf_d;
    end
  end

  // registered handshake and result outputs; ready derives from next state, not out_ready
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_ready_q     <= 1'b0;
      busy_q         <= 1'b0;
      out_valid_q    <= 1'b0;
      out_sum_q      <= {OUT_W{1'b0}};
      out_overflow_q <= 1'b0;
      out_count_q    <= {CNT_W{1'b0}};
    end else begin
      in_ready_q <= (state_d != DONE);
      busy_q     <= (state_d != IDLE);
      if (load_res) begin
        out_valid_q    <= 1'b1;
        out_sum_q      <= clamp_sum;
        out_overflow_q <= acc_ovf_d | clamp_oor;
        out_count_q    <= cnt_d;
      end else if (res_fire) begin
        out_valid_q <= 1'b0;
      end else begin
        out_valid_q <= out_valid_q;
      end
    end
  end

  assign bus.in_ready     = in_ready_q;
  assign bus.busy         = busy_q;
  assign bus.out_valid    = out_valid_q;
  assign bus.out_sum      = out_sum_q;
  assign bus.out_overflow = out_overflow_q;
  assign bus.out_count    = out_count_q;

endmodule

// File: tb/tb_booth_dot_accumulator.sv
// Randomised and directed bench for booth_dot_accumulator against an arithmetic frame model.
module tb_booth_dot_accumulator;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  booth_dot_accumulator_if bus ();

  booth_dot_accumulator dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Frame model: saturating 40-bit running sum, then 32-bit clamp or truncate
  function automatic void model(input logic [31:0] prods[$], input bit sat,
                                output logic [31:0] esum, output bit eovf, output logic [7:0] ecnt);
    longint acc, s, amax, amin;
    int     sp;
    bit     aovf;
    amax = (longint'(1) <<< 39) - 1;
    amin = -(longint'(1) <<< 39);
    acc  = 0;
    aovf = 0;
    foreach (prods[i]) begin
      sp = int'(prods[i]);
      s  = acc + longint'(sp);
      if (s > amax) begin s = amax; aovf = 1; end
      else if (s < amin) begin s = amin; aovf = 1; end
      acc = s;
    end
    eovf = aovf || (acc > 64'sd2147483647) || (acc < -64'sd2147483648);
    if (sat && acc > 64'sd2147483647)       esum = 32'h7FFF_FFFF;
    else if (sat && acc < -64'sd2147483648) esum = 32'h8000_0000;
    else                                    esum = 32'(acc);
    ecnt = (prods.size() > 255) ? 8'd255 : 8'(prods.size());
  endfunction

  task automatic push_beat(input logic [31:0] p, input bit last);
    int t;
    @(negedge clk);
    bus.in_valid   = 1'b1;
    bus.in_product = p;
    bus.in_last    = last;
    t = 0;
    while (!bus.in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) chk("in_ready_wait", 64'(bus.in_ready), 64'd1);
    @(posedge clk);
    #1;
    bus.in_valid   = 1'b0;
    bus.in_last    = 1'b0;
    bus.in_product = $urandom;
  endtask

  task automatic run_frame(input logic [31:0] prods[$], input bit sat, input int hold,
                           input bit gaps, input string tag);
    logic [31:0] esum, sum0;
    logic [7:0]  ecnt;
    bit          eovf, stable;
    model(prods, sat, esum, eovf, ecnt);
    bus.cfg_saturate = sat;
    foreach (prods[i]) begin
      if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
      push_beat(prods[i], i == prods.size() - 1);
    end
    @(negedge clk);
    chk({tag, "_valid_lat"}, 64'(bus.out_valid), 64'd1);
    chk({tag, "_ready_done"}, 64'(bus.in_ready), 64'd0);
    sum0   = bus.out_sum;
    stable = 1'b1;
    bus.cfg_saturate = ~sat;
    repeat (hold) begin
      @(negedge clk);
      if (!bus.out_valid || bus.out_sum !== sum0 || bus.in_ready) stable = 1'b0;
    end
    bus.cfg_saturate = sat;
    chk({tag, "_hold"}, 64'(stable), 64'd1);
    chk({tag, "_sum"}, 64'(bus.out_sum), 64'(esum));
    chk({tag, "_ovf"}, 64'(bus.out_overflow), 64'(eovf));
    chk({tag, "_cnt"}, 64'(bus.out_count), 64'(ecnt));
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    @(negedge clk);
    chk({tag, "_bubble"}, 64'(bus.in_ready), 64'd1);
    chk({tag, "_valid_clr"}, 64'(bus.out_valid), 64'd0);
  endtask

  initial begin
    logic [31:0] q[$];
    bit          seen;
    bus.in_valid     = 1'b0;
    bus.in_product   = 32'd0;
    bus.in_last      = 1'b0;
    bus.cfg_saturate = 1'b1;
    bus.out_ready    = 1'b0;

    repeat (2) @(negedge clk);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
    chk("rst_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_sum", 64'(bus.out_sum), 64'd0);
    rst = 1'b0;

    q = {};
    q.push_back(32'd3); q.push_back(32'hFFFF_FFFB); q.push_back(32'd100);
    run_frame(q, 1'b1, 0, 1'b0, "t1");

    q = {};
    q.push_back(32'hC000_0000);
    run_frame(q, 1'b1, 0, 1'b0, "t2");

    q = {};
    q.push_back(32'h7FFF_FFFF); q.push_back(32'h7FFF_FFFF);
    run_frame(q, 1'b1, 0, 1'b0, "t3sat");
    run_frame(q, 1'b0, 0, 1'b0, "t3trunc");

    q = {};
    q.push_back(32'd1); q.push_back(32'd2);
    run_frame(q, 1'b1, 5, 1'b0, "t4");

    q = {};
    repeat (300) q.push_back(32'd1);
    run_frame(q, 1'b1, 0, 1'b0, "t5cnt");
    q = {};
    repeat (256) q.push_back(32'h8000_0000);
    run_frame(q, 1'b1, 0, 1'b0, "t5neg");
    q = {};
    repeat (257) q.push_back(32'h8000_0000);
    repeat (256) q.push_back(32'h7FFF_FFFF);
    run_frame(q, 1'b0, 1, 1'b0, "t5sticky");

    push_beat(32'd5, 1'b0);
    push_beat(32'd9, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("t6_rst_valid", 64'(bus.out_valid), 64'd0);
    chk("t6_rst_sum", 64'(bus.out_sum), 64'd0);
    chk("t6_rst_in_ready", 64'(bus.in_ready), 64'd0);
    chk("t6_rst_busy", 64'(bus.busy), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (bus.out_valid) seen = 1'b1;
    end
    chk("t6_no_valid", 64'(seen), 64'd0);
    q = {};
    q.push_back(32'd7);
    run_frame(q, 1'b1, 0, 1'b0, "t6next");

    for (int f = 0; f < 25; f++) begin
      int n;
      n = $urandom_range(1, 6);
      q = {};
      for (int k = 0; k < n; k++) begin
        if ($urandom_range(0, 1) == 1) q.push_back($urandom);
        else q.push_back(32'($urandom_range(0, 200)) - 32'd100);
      end
      run_frame(q, 1'($urandom_range(0, 1)), $urandom_range(0, 3), 1'b1, "rnd");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
